// File: rtl/line_sensor_reader.sv
`default_nettype none
// ============================================================================
// Module   : line_sensor_reader
// Purpose  : Drives a linear image sensor through one line readout per
//            trigger and turns the ADC samples into a per-line pixel stream
//            (line_start, data_valid/data_out/data_pos, line_done).
// Ports    : clk_in      system clock
//            rst_in      synchronous active-high reset
//            trigger     line request, only honoured while idle
//            adc_data    8-bit ADC sample of the current sensor pixel
//            sens_clk    sensor pixel clock (period 2*CLK_DIV clk_in cycles)
//            sens_si     sensor start pulse, high for the first pixel period
//            busy        high from line_start through line_done
//            line_start  one-cycle pulse at the beginning of a line
//            data_valid  one-cycle strobe per captured pixel
//            data_out    captured pixel value, held between strobes
//            data_pos    pixel index of data_out, held between strobes
//            line_done   one-cycle pulse at the end of a completed line
// Revision : 1.0 - initial release
// ============================================================================
module line_sensor_reader #(
    parameter int PIXEL_COUNT  = 512,
    parameter int CLK_DIV      = 4,
    parameter int SAMPLE_PHASE = 6
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       trigger,
    input  logic [7:0] adc_data,
    output logic       sens_clk,
    output logic       sens_si,
    output logic       busy,
    output logic       line_start,
    output logic       data_valid,
    output logic [7:0] data_out,
    output logic [8:0] data_pos,
    output logic       line_done
);

    localparam int c_PERIOD = 2 * CLK_DIV;
    localparam int c_CW     = $clog2(c_PERIOD);

    localparam logic [c_CW-1:0] c_LAST_CNT = c_CW'(c_PERIOD - 1);
    localparam logic [c_CW-1:0] c_HALF     = c_CW'(CLK_DIV);
    localparam logic [c_CW-1:0] c_SAMPLE   = c_CW'(SAMPLE_PHASE);
    localparam logic [8:0]      c_LAST_PIX = 9'(PIXEL_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SI   = 2'd1,
        ST_READ = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          r_state;
    logic [c_CW-1:0] r_cnt;
    logic [8:0]      r_pix;
    logic [c_CW-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + c_CW'(1);

    // sens_clk is registered from the divider value the next cycle will
    // hold, so the pin is high exactly in the cycles where cnt >= CLK_DIV.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_pix      <= '0;
            sens_clk   <= 1'b0;
            sens_si    <= 1'b0;
            busy       <= 1'b0;
            line_start <= 1'b0;
            data_valid <= 1'b0;
            data_out   <= '0;
            data_pos   <= '0;
            line_done  <= 1'b0;
        end else begin
            line_start <= 1'b0;
            data_valid <= 1'b0;
            line_done  <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_cnt    <= '0;
                    sens_clk <= 1'b0;
                    sens_si  <= 1'b0;
                    busy     <= 1'b0;
                    if (trigger) begin
                        r_state    <= ST_SI;
                        line_start <= 1'b1;
                        busy       <= 1'b1;
                        sens_si    <= 1'b1;
                    end
                end

                // One full sensor clock period with SI high clocks the
                // start bit into the sensor's shift register.
                ST_SI: begin
                    if (r_cnt == c_LAST_CNT) begin
                        r_state  <= ST_READ;
                        r_cnt    <= '0;
                        r_pix    <= '0;
                        sens_si  <= 1'b0;
                        sens_clk <= 1'b0;
                    end else begin
                        r_cnt    <= w_cnt_inc;
                        sens_clk <= (w_cnt_inc >= c_HALF);
                    end
                end

                ST_READ: begin
                    if (r_cnt == c_SAMPLE) begin
                        data_out   <= adc_data;
                        data_pos   <= r_pix;
                        data_valid <= 1'b1;
                    end
                    if (r_cnt == c_LAST_CNT) begin
                        r_cnt    <= '0;
                        sens_clk <= 1'b0;
                        if (r_pix == c_LAST_PIX) begin
                            r_state   <= ST_DONE;
                            line_done <= 1'b1;
                        end else begin
                            r_pix <= r_pix + 9'd1;
                        end
                    end else begin
                        r_cnt    <= w_cnt_inc;
                        sens_clk <= (w_cnt_inc >= c_HALF);
                    end
                end

                // Single cycle carrying line_done; busy drops on exit.
                ST_DONE: begin
                    r_state  <= ST_IDLE;
                    r_cnt    <= '0;
                    sens_clk <= 1'b0;
                    busy     <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
